// File: rtl/key_event_decoder_if.sv
// Key pin and command-pulse bundle for one front-panel key decoder.
// Pulses carry no valid/ready: each is a one-cycle strobe the consumer must sample, there is no backpressure.
interface key_event_decoder_if;
    logic key_in;
    logic key_level;
    logic short_out;
    logic long_out;
    logic double_out;
    logic repeat_out;

    modport master (
        output key_in,
        input  key_level,
        input  short_out,
        input  long_out,
        input  double_out,
        input  repeat_out
    );

    modport slave (
        input  key_in,
        output key_level,
        output short_out,
        output long_out,
        output double_out,
        output repeat_out
    );
endinterface

// File: rtl/key_event_decoder.sv
// Push-button front end: sync, debounce, and short/long/double gesture pulses.
// Auto-repeat while long-held is built only when KEY_REPEAT_EN is defined.
module key_event_decoder #(
    parameter logic [19:0] DEB_MAX    = 20'd999_999,
    parameter logic [25:0] LONG_MAX   = 26'd49_999_999,
    parameter logic [23:0] GAP_MAX    = 24'd14_999_999,
    parameter logic [23:0] REPEAT_MAX = 24'd9_999_999
) (
    input  logic                  clk,
    input  logic                  rst,
    key_event_decoder_if.slave    kif,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        sync2_q;
    logic        key_st_q;
    logic        key_st_d;
    logic        key_st_dly_q;
    logic [19:0] deb_cnt_q;
    logic [19:0] deb_cnt_d;
    logic [25:0] hold_cnt_q;
    logic [23:0] gap_cnt_q;
    logic        key_level_q;
    logic        short_q;
    logic        long_q;
    logic        double_q;
    logic        repeat_q;
    logic        press_evt;
    logic        rel_evt;

    // key_in is 0 when pressed, so the stable level idles at 1.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        key_st_d  = key_st_q;
        if (sync2_q == key_st_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            key_st_d  = sync2_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q != '1) begin
            deb_cnt_d = deb_cnt_q + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            key_st_q     <= 1'b1;
            key_st_dly_q <= 1'b1;
            deb_cnt_q    <= '0;
            key_level_q  <= 1'b0;
        end else begin
            sync1_q      <= kif.key_in;
            sync2_q      <= sync1_q;
            key_st_q     <= key_st_d;
            key_st_dly_q <= key_st_q;
            deb_cnt_q    <= deb_cnt_d;
            key_level_q  <= ~key_st_q;
        end
    end

    assign press_evt = key_st_dly_q & ~key_st_q;
    assign rel_evt   = ~key_st_dly_q & key_st_q;

`ifdef KEY_REPEAT_EN
    logic [23:0] rep_cnt_q;
`else
    logic unused_repeat_max;
    assign unused_repeat_max = ^REPEAT_MAX;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            double_q   <= 1'b0;
            repeat_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_evt) begin
                        state_q    <= PRESS1;
                        hold_cnt_q <= '0;
                    end
                end
                PRESS1: begin
                    if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + 26'd1;
                    end
                    // A release landing on the long threshold still counts as long.
                    if (hold_cnt_q == LONG_MAX) begin
                        long_q  <= 1'b1;
                        state_q <= rel_evt ? IDLE : LONG_HOLD;
`ifdef KEY_REPEAT_EN
                        rep_cnt_q <= '0;
`endif
                    end else if (rel_evt) begin
                        state_q   <= WAIT2;
                        gap_cnt_q <= '0;
                    end
                end
                WAIT2: begin
                    if (gap_cnt_q != '1) begin
                        gap_cnt_q <= gap_cnt_q + 24'd1;
                    end
                    if (press_evt) begin
                        double_q <= 1'b1;
                        state_q  <= PRESS2;
                    end else if (gap_cnt_q == GAP_MAX) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                PRESS2: begin
                    if (rel_evt) begin
                        state_q <= IDLE;
                    end
                end
                LONG_HOLD: begin
                    if (rel_evt) begin
                        state_q <= IDLE;
                    end
`ifdef KEY_REPEAT_EN
                    if (rel_evt) begin
                        rep_cnt_q <= '0;
                    end else if (rep_cnt_q == REPEAT_MAX) begin
                        repeat_q  <= 1'b1;
                        rep_cnt_q <= '0;
                    end else if (rep_cnt_q != '1) begin
                        rep_cnt_q <= rep_cnt_q + 24'd1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign kif.key_level  = key_level_q;
    assign kif.short_out  = short_q;
    assign kif.long_out   = long_q;
    assign kif.double_out = double_q;
    assign kif.repeat_out = repeat_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: gesture table plus a timed-event scoreboard and a reset-mid-gesture sequence.
module tb_key_event_decoder;

    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_DOUBLE = 3;
    localparam int K_REP    = 4;
    localparam int K_RISE   = 5;
    localparam int K_FALL   = 6;
    localparam int WINDOW   = 80;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]        a;
        logic [7:0]        b;
        logic [7:0]        c;
        logic [2:0]        n_ev;
        logic [5:0][15:0]  ev;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  dbg_state;
    int          cyc;
    int          base;
    int          n_checks;
    int          n_fail;
    bit          mon_en;
    logic        lvl_prev;
    logic [15:0] exp_q[$];
    vec_t        vecs [11];

    key_event_decoder_if kif ();

    key_event_decoder #(
        .DEB_MAX    (20'd3),
        .LONG_MAX   (26'd20),
        .GAP_MAX    (24'd10),
        .REPEAT_MAX (24'd5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kif         (kif.slave),
        .dbg_state_o (dbg_state)
    );

    // Clock and cycle counter; cyc equals the number of rising edges seen.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ev_at(input int kind, input int t);
        logic [3:0]  k4;
        logic [11:0] t12;
        k4  = 4'(kind);
        t12 = 12'(t);
        return {k4, t12};
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int n,
                                input logic [15:0] e0 = '0, input logic [15:0] e1 = '0,
                                input logic [15:0] e2 = '0, input logic [15:0] e3 = '0,
                                input logic [15:0] e4 = '0, input logic [15:0] e5 = '0);
        vec_t v;
        v       = '0;
        v.a     = 8'(a);
        v.b     = 8'(b);
        v.c     = 8'(c);
        v.n_ev  = 3'(n);
        v.ev[0] = e0;
        v.ev[1] = e1;
        v.ev[2] = e2;
        v.ev[3] = e3;
        v.ev[4] = e4;
        v.ev[5] = e5;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] e);
        if (int'(e[15:12]) != K_REP || REP_EN) begin
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard consumer: every observed event must be the next expected {kind, time}.
    task automatic got(input int kind, input int t);
        logic [15:0] act;
        logic [15:0] exp;
        act = ev_at(kind, t);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at t=%0d expected none", kind, t);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL event: got kind %0d at t=%0d expected kind %0d at t=%0d",
                         kind, t, exp[15:12], exp[11:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (kif.key_level && !lvl_prev)  got(K_RISE, cyc - base);
            if (!kif.key_level && lvl_prev)  got(K_FALL, cyc - base);
            if (kif.short_out)               got(K_SHORT, cyc - base);
            if (kif.long_out)                got(K_LONG, cyc - base);
            if (kif.double_out)              got(K_DOUBLE, cyc - base);
            if (kif.repeat_out)              got(K_REP, cyc - base);
        end
        lvl_prev <= kif.key_level;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(posedge clk);
        #1;
    endtask

    function automatic int outs_now();
        return {27'd0, kif.key_level, kif.short_out, kif.long_out, kif.double_out, kif.repeat_out};
    endfunction

    // Driver: key low for a cycles, high for b, low for c (second press only when c > 0).
    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(posedge clk);
        #1;
        base = cyc + 1;
        for (int i = 0; i < int'(v.n_ev); i++) push_exp(v.ev[i]);
        mon_en = 1'b1;
        kif.key_in = 1'b0;
        wait_cycles(int'(v.a));
        kif.key_in = 1'b1;
        if (v.c != 0) begin
            wait_cycles(int'(v.b));
            kif.key_in = 1'b0;
            wait_cycles(int'(v.c));
            kif.key_in = 1'b1;
        end
        wait_until(base + WINDOW);
        check($sformatf("vec%0d_idle_state", idx), int'(dbg_state), 0);
        check($sformatf("vec%0d_missing_events", idx), exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        base       = 0;
        rst        = 1'b0;
        kif.key_in = 1'b1;

        // Times are cycles after the first edge that samples key_in low.
        vecs[0]  = mk(2, 0, 0, 0);
        vecs[1]  = mk(3, 0, 0, 0);
        vecs[2]  = mk(4, 0, 0, 3, ev_at(K_RISE, 6), ev_at(K_FALL, 10), ev_at(K_SHORT, 21));
        vecs[3]  = mk(10, 0, 0, 3, ev_at(K_RISE, 6), ev_at(K_FALL, 16), ev_at(K_SHORT, 27));
        vecs[4]  = mk(20, 0, 0, 3, ev_at(K_RISE, 6), ev_at(K_FALL, 26), ev_at(K_SHORT, 37));
        vecs[5]  = mk(21, 0, 0, 3, ev_at(K_RISE, 6), ev_at(K_FALL, 27), ev_at(K_LONG, 27));
        vecs[6]  = mk(40, 0, 0, 6, ev_at(K_RISE, 6), ev_at(K_LONG, 27), ev_at(K_REP, 33),
                      ev_at(K_REP, 39), ev_at(K_REP, 45), ev_at(K_FALL, 46));
        vecs[7]  = mk(10, 6, 10, 5, ev_at(K_RISE, 6), ev_at(K_FALL, 16), ev_at(K_RISE, 22),
                      ev_at(K_DOUBLE, 22), ev_at(K_FALL, 32));
        vecs[8]  = mk(10, 20, 10, 6, ev_at(K_RISE, 6), ev_at(K_FALL, 16), ev_at(K_SHORT, 27),
                      ev_at(K_RISE, 36), ev_at(K_FALL, 46), ev_at(K_SHORT, 57));
        vecs[9]  = mk(10, 11, 10, 5, ev_at(K_RISE, 6), ev_at(K_FALL, 16), ev_at(K_RISE, 27),
                      ev_at(K_DOUBLE, 27), ev_at(K_FALL, 37));
        vecs[10] = mk(10, 12, 10, 6, ev_at(K_RISE, 6), ev_at(K_FALL, 16), ev_at(K_SHORT, 27),
                      ev_at(K_RISE, 28), ev_at(K_FALL, 38), ev_at(K_SHORT, 49));

        wait_cycles(3);
        check("reset_outputs", outs_now(), 0);
        check("reset_state", int'(dbg_state), 0);
        rst = 1'b1;
        wait_cycles(5);
        check("post_reset_outputs", outs_now(), 0);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Reset asserted mid-press: gesture is dropped, held key re-accepted as a fresh press.
        @(posedge clk);
        #1;
        base = cyc + 1;
        push_exp(ev_at(K_RISE, 6));
        kif.key_in = 1'b0;
        wait_cycles(14);
        check("mid_press_state", int'(dbg_state), 1);
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("in_reset_outputs", outs_now(), 0);
        check("in_reset_state", int'(dbg_state), 0);
        wait_cycles(4);
        check("in_reset_outputs_held", outs_now(), 0);
        rst  = 1'b1;
        base = cyc + 1;
        push_exp(ev_at(K_RISE, 6));
        push_exp(ev_at(K_FALL, 14));
        push_exp(ev_at(K_SHORT, 25));
        mon_en = 1'b1;
        wait_cycles(8);
        kif.key_in = 1'b1;
        wait_until(base + 60);
        check("rst_seq_idle_state", int'(dbg_state), 0);
        check("rst_seq_missing_events", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
